// File: rtl/gsm_coef_bank_ctrl.sv
// Double-buffered coefficient bank controller for the symmetric FIR.
// Loads a shadow bank, swaps on a sample strobe, then mutes while the tree drains.
module gsm_coef_bank_ctrl #(
  parameter int WIDTH     = 18,
  parameter int NUM_COEF  = 51,
  parameter int FLUSH_LEN = 8
) (
  input  logic                      sys_clk,
  input  logic                      reset,
  input  logic                      sam_clk_en,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic                      wr_last,
  output logic [NUM_COEF*WIDTH-1:0] coef_bus,
  output logic                      bank_sel,
  output logic                      mute,
  output logic                      busy,
  output logic                      load_err,
  output logic                      swap_done
);

  localparam int IW = $clog2(NUM_COEF);
  localparam int FW = $clog2(FLUSH_LEN + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_PEND  = 2'd2;
  localparam logic [1:0] S_FLUSH = 2'd3;

  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_COEF - 1);
  localparam logic [FW-1:0] FL_INIT  = FW'(FLUSH_LEN);
  localparam logic [FW-1:0] FL_ONE   = FW'(1);

  logic [WIDTH-1:0] r_bank [2][NUM_COEF];

  logic [1:0]    r_state;
  logic [IW-1:0] r_widx;
  logic [FW-1:0] r_flush_cnt;
  logic          r_bank_sel;
  logic          r_mute;
  logic          r_busy;
  logic          r_load_err;
  logic          r_swap_done;

  logic [1:0]    w_state_nxt;
  logic [IW-1:0] w_widx_nxt;
  logic [FW-1:0] w_cnt_nxt;
  logic          w_sel_nxt;
  logic          w_mute_nxt;
  logic          w_err_nxt;
  logic          w_done_nxt;
  logic          w_ready;
  logic          w_acc;
  logic          w_we;
  logic [IW-1:0] w_waddr;
  logic          w_wbank;

  // Ready depends only on state, never on wr_valid.
  assign w_ready = (r_state == S_IDLE) ||
                   (r_state == S_LOAD);
  assign w_acc   = wr_valid && w_ready;
  assign w_wbank = ~r_bank_sel;

  always_comb begin
    w_state_nxt = r_state;
    w_widx_nxt  = r_widx;
    w_cnt_nxt   = r_flush_cnt;
    w_sel_nxt   = r_bank_sel;
    w_mute_nxt  = r_mute;
    w_err_nxt   = r_load_err;
    w_done_nxt  = 1'b0;
    w_we        = 1'b0;
    w_waddr     = r_widx;
    unique case (r_state)
      S_IDLE: begin
        if (w_acc) begin
          w_we    = 1'b1;
          w_waddr = '0;
          if (wr_last) begin
            w_err_nxt = 1'b1;
          end else begin
            w_err_nxt   = 1'b0;
            w_widx_nxt  = IW'(1);
            w_state_nxt = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (w_acc) begin
          w_we = 1'b1;
          if (r_widx == LAST_IDX) begin
            if (wr_last) begin
              w_state_nxt = S_PEND;
            end else begin
              w_err_nxt   = 1'b1;
              w_state_nxt = S_IDLE;
            end
          end else if (wr_last) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_widx_nxt = r_widx + 1'b1;
          end
        end
      end
      S_PEND: begin
        if (sam_clk_en) begin
          w_sel_nxt   = ~r_bank_sel;
          w_cnt_nxt   = FL_INIT;
          w_mute_nxt  = 1'b1;
          w_state_nxt = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (sam_clk_en) begin
          w_cnt_nxt = r_flush_cnt - 1'b1;
          if (r_flush_cnt == FL_ONE) begin
            w_mute_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_widx      <= '0;
      r_flush_cnt <= '0;
      r_bank_sel  <= 1'b0;
      r_mute      <= 1'b0;
      r_busy      <= 1'b0;
      r_load_err  <= 1'b0;
      r_swap_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_widx      <= w_widx_nxt;
      r_flush_cnt <= w_cnt_nxt;
      r_bank_sel  <= w_sel_nxt;
      r_mute      <= w_mute_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
      r_load_err  <= w_err_nxt;
      r_swap_done <= w_done_nxt;
    end
  end

  // Writes only ever target the shadow bank.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_COEF; k++) begin
        r_bank[0][k] <= '0;
        r_bank[1][k] <= '0;
      end
    end else if (w_we) begin
      r_bank[w_wbank][w_waddr] <= wr_data;
    end
  end

  for (genvar k = 0; k < NUM_COEF; k++) begin : g_bus
    assign coef_bus[WIDTH*k +: WIDTH] =
      r_bank[r_bank_sel][k];
  end

  assign wr_ready  = w_ready;
  assign bank_sel  = r_bank_sel;
  assign mute      = r_mute;
  assign busy      = r_busy;
  assign load_err  = r_load_err;
  assign swap_done = r_swap_done;

endmodule
